// File: rtl/schoening_solver_pkg.sv
// Shared definitions for the Schoening 3SAT engine: state encodings,
// width helper and the randomness source polynomial.
package schoening_solver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_SEARCH = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Bits needed to index v items; never less than 1.
    function automatic int log2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/schoening_solver_random_pick.sv
// random_pick: chooses one set bit of i_vec, starting the priority search at
// position i_rot, so each candidate gets picked depending on the random offset.
module random_pick
    import schoening_solver_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]          i_vec,
    input  logic [log2c(W)-1:0]   i_rot,
    output logic [W-1:0]          o_onehot,
    output logic [log2c(W)-1:0]   o_idx,
    output logic                  o_none
);

    localparam int RW = log2c(W);

    logic [RW-1:0] w_r;
    logic [W-1:0]  w_rot;
    logic [W-1:0]  w_low;

    always_comb begin
        // Offsets past W fold back once; the field is narrower than 2*W.
        if ({1'b0, i_rot} >= (RW+1)'(W)) w_r = i_rot - RW'(W);
        else                              w_r = i_rot;
        w_rot    = W'({i_vec, i_vec} >> w_r);
        w_low    = w_rot & (-w_rot);
        o_onehot = W'(({w_low, w_low} << w_r) >> W);
        o_idx    = '0;
        for (int i = 0; i < W; i++) begin
            if (o_onehot[i]) o_idx = o_idx | RW'(i);
        end
        o_none = ~|i_vec;
    end

endmodule

// File: rtl/schoening_solver.sv
// Schoening random-walk 3SAT engine with loadable clause table and bounded
// restarts. Define SCHOENING_STATS_EN to add flips_total/restarts counters.
//   state     | meaning
//   ST_IDLE   | after reset, table writable, waiting for start
//   ST_INIT   | load random assignment, reload flip budget, count a try
//   ST_SEARCH | check clauses, flip one literal per cycle
//   ST_DONE   | result held, table writable, waiting for start
module schoening_solver
    import schoening_solver_pkg::*;
#(
    parameter int          N     = 32,
    parameter int          M     = 16,
    parameter int          FLIPS = 3*N,
    parameter int          TRIES = 64,
    parameter logic [31:0] SEED  = 32'hACE1_0001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [log2c(M)-1:0]   cfg_addr,
    input  logic [N-1:0]          cfg_pos,
    input  logic [N-1:0]          cfg_neg,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  sat,
    output logic [N-1:0]          solution,
    output logic [15:0]           tries_used
`ifdef SCHOENING_STATS_EN
    ,
    output logic [31:0]           flips_total,
    output logic [15:0]           restarts
`endif
);

    localparam int CW = log2c(M);
    localparam int LW = log2c(N);
    localparam int FW = log2c(FLIPS + 1);

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_pos [M];
    logic [N-1:0]  r_neg [M];
    logic [N-1:0]  r_x;
    logic [N-1:0]  r_solution;
    logic [31:0]   r_lfsr;
    logic [FW-1:0] r_flip_cnt;
    logic [15:0]   r_tries;
    logic          r_done, r_sat;

    logic [M-1:0]  w_unsat, w_c_onehot;
    logic [CW-1:0] w_c_idx;
    logic          w_all_sat;
    logic [N-1:0]  w_lits, w_flip;
    logic [LW-1:0] w_l_idx;
    logic          w_l_none;
    logic          w_unused_pick;
    logic          w_cfg_ok, w_accept, w_do_init, w_do_flip, w_do_sat, w_do_fail, w_do_restart;

    // Empty slots (pos==neg==0) never report unsatisfied.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            w_unsat[i] = (|(r_pos[i] | r_neg[i])) &&
                         !((|(r_pos[i] & r_x)) || (|(r_neg[i] & ~r_x)));
        end
    end

    random_pick #(.W(M)) u_pick_clause (
        .i_vec    (w_unsat),
        .i_rot    (r_lfsr[CW-1:0]),
        .o_onehot (w_c_onehot),
        .o_idx    (w_c_idx),
        .o_none   (w_all_sat)
    );

    always_comb begin
        w_lits = '0;
        for (int i = 0; i < M; i++) begin
            if (w_c_onehot[i]) w_lits = w_lits | r_pos[i] | r_neg[i];
        end
    end

    random_pick #(.W(N)) u_pick_lit (
        .i_vec    (w_lits),
        .i_rot    (r_lfsr[CW+LW-1:CW]),
        .o_onehot (w_flip),
        .o_idx    (w_l_idx),
        .o_none   (w_l_none)
    );

    assign w_unused_pick = ^{w_c_idx, w_l_idx};

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_do_init    = 1'b0;
        w_do_flip    = 1'b0;
        w_do_sat     = 1'b0;
        w_do_fail    = 1'b0;
        w_do_restart = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                w_do_init   = 1'b1;
                w_state_nxt = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (w_all_sat) begin
                    w_do_sat    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (r_flip_cnt == '0) begin
                    if ((TRIES != 0) && (r_tries == 16'(TRIES))) begin
                        w_do_fail   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_do_restart = 1'b1;
                        w_state_nxt  = ST_INIT;
                    end
                end else if (!w_l_none) begin
                    w_do_flip = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_cfg_ok = cfg_we && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lfsr     <= SEED;
            r_x        <= '0;
            r_solution <= '0;
            r_flip_cnt <= '0;
            r_tries    <= '0;
            r_done     <= 1'b0;
            r_sat      <= 1'b0;
            for (int i = 0; i < M; i++) begin
                r_pos[i] <= '0;
                r_neg[i] <= '0;
            end
        end else begin
            r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
            if (w_cfg_ok && (int'(cfg_addr) < M)) begin
                r_pos[cfg_addr] <= cfg_pos;
                r_neg[cfg_addr] <= cfg_neg;
            end
            if (w_accept) begin
                r_done     <= 1'b0;
                r_sat      <= 1'b0;
                r_solution <= '0;
                r_tries    <= '0;
            end
            if (w_do_init) begin
                for (int i = 0; i < N; i++) r_x[i] <= r_lfsr[i % 32];
                r_flip_cnt <= FW'(FLIPS);
                if (r_tries != 16'hFFFF) r_tries <= r_tries + 16'd1;
            end
            if (w_do_flip) begin
                r_x        <= r_x ^ w_flip;
                r_flip_cnt <= r_flip_cnt - FW'(1);
            end
            if (w_do_sat) begin
                r_solution <= r_x;
                r_sat      <= 1'b1;
                r_done     <= 1'b1;
            end
            if (w_do_fail) begin
                r_solution <= '0;
                r_sat      <= 1'b0;
                r_done     <= 1'b1;
            end
        end
    end

    assign busy       = (r_state == ST_INIT) || (r_state == ST_SEARCH);
    assign done       = r_done;
    assign sat        = r_sat;
    assign solution   = r_solution;
    assign tries_used = r_tries;

`ifdef SCHOENING_STATS_EN
    logic [31:0] r_flips_total;
    logic [15:0] r_restarts;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flips_total <= '0;
            r_restarts    <= '0;
        end else if (w_accept) begin
            r_flips_total <= '0;
            r_restarts    <= '0;
        end else begin
            if (w_do_flip && (r_flips_total != 32'hFFFF_FFFF)) r_flips_total <= r_flips_total + 32'd1;
            if (w_do_restart && (r_restarts != 16'hFFFF))      r_restarts    <= r_restarts + 16'd1;
        end
    end

    assign flips_total = r_flips_total;
    assign restarts    = r_restarts;
`endif

endmodule

// File: tb/tb_schoening_solver.sv
// Bench for schoening_solver: a satisfiable-table instance (A) and a small
// bounded-restart instance (B) driven by a run table plus corner sequences.
module tb_schoening_solver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: N=4, M=5, unlimited tries
    logic        a_reset, a_we, a_start;
    logic [2:0]  a_addr;
    logic [3:0]  a_pos, a_neg;
    logic        a_busy, a_done, a_sat;
    logic [3:0]  a_sol;
    logic [15:0] a_tries;
    // Instance B: N=4, M=2, FLIPS=4, TRIES=3
    logic        b_reset, b_we, b_start;
    logic [0:0]  b_addr;
    logic [3:0]  b_pos, b_neg;
    logic        b_busy, b_done, b_sat;
    logic [3:0]  b_sol;
    logic [15:0] b_tries;
`ifdef SCHOENING_STATS_EN
    logic [31:0] a_flips, b_flips;
    logic [15:0] a_rest, b_rest;
`endif

    schoening_solver #(.N(4), .M(5), .FLIPS(12), .TRIES(0)) u_dut_a (
        .clk(clk), .reset(a_reset), .cfg_we(a_we), .cfg_addr(a_addr),
        .cfg_pos(a_pos), .cfg_neg(a_neg), .start(a_start), .busy(a_busy),
        .done(a_done), .sat(a_sat), .solution(a_sol), .tries_used(a_tries)
`ifdef SCHOENING_STATS_EN
        , .flips_total(a_flips), .restarts(a_rest)
`endif
    );

    schoening_solver #(.N(4), .M(2), .FLIPS(4), .TRIES(3)) u_dut_b (
        .clk(clk), .reset(b_reset), .cfg_we(b_we), .cfg_addr(b_addr),
        .cfg_pos(b_pos), .cfg_neg(b_neg), .start(b_start), .busy(b_busy),
        .done(b_done), .sat(b_sat), .solution(b_sol), .tries_used(b_tries)
`ifdef SCHOENING_STATS_EN
        , .flips_total(b_flips), .restarts(b_rest)
`endif
    );

    typedef struct {
        logic [3:0]  p0, n0, p1, n1;
        logic        sat;
        int          lat_min, lat_max;
        logic [15:0] tries;
        logic [31:0] flips;
        logic [15:0] restarts;
    } run_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic clause_ok(input logic [3:0] p, input logic [3:0] n, input logic [3:0] x);
        return ((p == 4'd0) && (n == 4'd0)) || (|(p & x)) || (|(n & ~x));
    endfunction

    task automatic b_write(input logic [0:0] addr, input logic [3:0] p, input logic [3:0] n);
        b_we = 1'b1; b_addr = addr; b_pos = p; b_neg = n;
        @(posedge clk); #1;
        b_we = 1'b0;
    endtask

    task automatic a_write(input logic [2:0] addr, input logic [3:0] p, input logic [3:0] n);
        a_we = 1'b1; a_addr = addr; a_pos = p; a_neg = n;
        @(posedge clk); #1;
        a_we = 1'b0;
    endtask

    // lat = edges after the start-sampling edge until done is seen high
    task automatic b_run(output int lat);
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        lat = 0;
        while (!b_done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!b_done) begin
            errors++; checks++;
            $display("FAIL b_timeout actual=done0 required=done1");
        end
    endtask

    task automatic a_run(output int lat);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        lat = 0;
        while (!a_done && lat < 5000) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!a_done) begin
            errors++; checks++;
            $display("FAIL a_timeout actual=done0 required=done1");
        end
    endtask

    logic [3:0] a_tp [5];
    logic [3:0] a_tn [5];

    initial begin
        run_vec_t vecs [7];
        int lat;
        int busy_drops;
        string tag;

        vecs[0] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 2,  2, 16'd1, 32'd0,  16'd0};
        vecs[1] = '{4'h1, 4'h0, 4'h0, 4'h1, 1'b0, 18, 18, 16'd3, 32'd12, 16'd2};
        vecs[2] = '{4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 2,  3, 16'd1, 32'd0,  16'd0};
        vecs[3] = '{4'h0, 4'h2, 4'h4, 4'h0, 1'b1, 2,  4, 16'd1, 32'd0,  16'd0};
        vecs[4] = '{4'h3, 4'h0, 4'h0, 4'h3, 1'b1, 2,  3, 16'd1, 32'd0,  16'd0};
        vecs[5] = '{4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 2,  2, 16'd1, 32'd0,  16'd0};
        vecs[6] = '{4'h1, 4'h0, 4'h0, 4'h1, 1'b0, 18, 18, 16'd3, 32'd12, 16'd2};

        a_tp = '{4'b0011, 4'b0110, 4'b1100, 4'b0000, 4'b0000};
        a_tn = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001};

        a_reset = 1'b0; a_we = 1'b0; a_start = 1'b0; a_addr = '0; a_pos = '0; a_neg = '0;
        b_reset = 1'b0; b_we = 1'b0; b_start = 1'b0; b_addr = '0; b_pos = '0; b_neg = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_a_done", 32'(a_done), 32'd0);
        chk("rst_a_sat",  32'(a_sat),  32'd0);
        chk("rst_a_sol",  32'(a_sol),  32'd0);
        chk("rst_a_tries", 32'(a_tries), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        chk("rst_b_done", 32'(b_done), 32'd0);
`ifdef SCHOENING_STATS_EN
        chk("rst_a_flips", a_flips, 32'd0);
        chk("rst_a_rest",  32'(a_rest), 32'd0);
`endif
        a_reset = 1'b1; b_reset = 1'b1;

        // Empty table: satisfied on the first search cycle.
        a_run(lat);
        chk("a_empty_lat",   32'(lat), 32'd2);
        chk("a_empty_sat",   32'(a_sat), 32'd1);
        chk("a_empty_tries", 32'(a_tries), 32'd1);
        chk("a_empty_busy",  32'(a_busy), 32'd0);

        // Unique-solution table: only x = 4'b0110 satisfies all five clauses.
        for (int i = 0; i < 5; i++) a_write(3'(i), a_tp[i], a_tn[i]);
        a_run(lat);
        chk("a_tbl_sat", 32'(a_sat), 32'd1);
        chk("a_tbl_sol", 32'(a_sol), 32'b0110);
        for (int i = 0; i < 5; i++) begin
            $sformat(tag, "a_tbl_clause%0d", i);
            chk(tag, 32'(clause_ok(a_tp[i], a_tn[i], a_sol)), 32'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("a_done_held", 32'(a_done), 32'd1);
        chk("a_sol_held",  32'(a_sol), 32'b0110);

        // Run table on instance B.
        for (int v = 0; v < 7; v++) begin
            b_write(1'b0, vecs[v].p0, vecs[v].n0);
            b_write(1'b1, vecs[v].p1, vecs[v].n1);
            b_run(lat);
            checks++;
            if (lat < vecs[v].lat_min || lat > vecs[v].lat_max) begin
                errors++;
                $display("FAIL vec%0d_lat actual=%0d required=%0d..%0d", v, lat, vecs[v].lat_min, vecs[v].lat_max);
            end
            $sformat(tag, "vec%0d_sat", v);   chk(tag, 32'(b_sat), 32'(vecs[v].sat));
            $sformat(tag, "vec%0d_tries", v); chk(tag, 32'(b_tries), 32'(vecs[v].tries));
            $sformat(tag, "vec%0d_busy", v);  chk(tag, 32'(b_busy), 32'd0);
            if (vecs[v].sat) begin
                $sformat(tag, "vec%0d_cl0", v); chk(tag, 32'(clause_ok(vecs[v].p0, vecs[v].n0, b_sol)), 32'd1);
                $sformat(tag, "vec%0d_cl1", v); chk(tag, 32'(clause_ok(vecs[v].p1, vecs[v].n1, b_sol)), 32'd1);
            end else begin
                $sformat(tag, "vec%0d_sol", v); chk(tag, 32'(b_sol), 32'd0);
            end
`ifdef SCHOENING_STATS_EN
            $sformat(tag, "vec%0d_flips", v);
            chk(tag, b_flips, vecs[v].sat ? 32'(lat - 2) : vecs[v].flips);
            $sformat(tag, "vec%0d_restarts", v);
            chk(tag, 32'(b_rest), 32'(vecs[v].restarts));
`endif
        end

        // start and cfg_we during SEARCH must be ignored (table holds x0, ~x0).
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        lat = 0;
        busy_drops = 0;
        while (!b_done && lat < 400) begin
            if (lat == 3) begin
                b_start = 1'b1; b_we = 1'b1; b_addr = 1'b0; b_pos = 4'h0; b_neg = 4'h0;
            end
            @(posedge clk); #1;
            b_start = 1'b0; b_we = 1'b0;
            lat++;
            if (!b_done && !b_busy) busy_drops++;
        end
        chk("ign_lat",   32'(lat), 32'd18);
        chk("ign_busy",  32'(busy_drops), 32'd0);
        chk("ign_sat",   32'(b_sat), 32'd0);
        chk("ign_tries", 32'(b_tries), 32'd3);
        b_run(lat);
        chk("ign_table_sat", 32'(b_sat), 32'd0);
        chk("ign_table_lat", 32'(lat), 32'd18);

        // Reset mid-SEARCH aborts and clears the table.
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy_pre", 32'(b_busy), 32'd1);
        b_reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy",  32'(b_busy), 32'd0);
        chk("mid_done",  32'(b_done), 32'd0);
        chk("mid_sat",   32'(b_sat), 32'd0);
        chk("mid_tries", 32'(b_tries), 32'd0);
        b_reset = 1'b1;
        b_run(lat);
        chk("cleared_lat", 32'(lat), 32'd2);
        chk("cleared_sat", 32'(b_sat), 32'd1);
        b_write(1'b0, 4'h1, 4'h0);
        b_write(1'b1, 4'h0, 4'h1);
        b_run(lat);
        chk("reload_sat",   32'(b_sat), 32'd0);
        chk("reload_tries", 32'(b_tries), 32'd3);
        chk("reload_lat",   32'(lat), 32'd18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
